// File: rtl/uart_link_pkg.sv
// Shared constants for the UART link: register-block addresses, status bit
// positions and the state encodings used by the bus and receive FSMs.
package uart_link_pkg;

   localparam logic [7:0] UART_AN_ADDR   = 8'h10;
   localparam logic [7:0] UART_TX_ADDR   = 8'h18;
   localparam logic [7:0] UART_RX_ADDR   = 8'h1C;
   localparam logic [7:0] UART_STAT_ADDR = 8'h20;

   localparam int STAT_TX_DONE = 2;
   localparam int STAT_RX_DONE = 3;

   typedef enum logic [1:0] {
      B_IDLE  = 2'd0,
      B_POLL  = 2'd1,
      B_FETCH = 2'd2,
      B_WRITE = 2'd3
   } bus_state_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_link_rx_core.sv
// Serial receiver: 2-FF synchronizer, mid-bit sampling timer and LSB-first
// deserializer. byte_valid is a combinational strobe on the stop-sample cycle.
module uart_rx_core
   import uart_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             sync1_reg, sync2_reg, prev_reg;
   rx_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_reg, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic             frame_err_reg, frame_err_next;

   // Line idles high, so the synchronizer resets high to avoid a false start.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         prev_reg  <= 1'b1;
      end else begin
         sync1_reg <= rx;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= R_IDLE;
         cnt_reg       <= '0;
         bit_reg       <= 3'd0;
         shift_reg     <= 8'h00;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bit_reg       <= bit_next;
         shift_reg     <= shift_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg + 1'b1;
      bit_next       = bit_reg;
      shift_next     = shift_reg;
      frame_err_next = 1'b0;
      byte_valid     = 1'b0;
      case (state_reg)
         R_IDLE: begin
            cnt_next = '0;
            if (prev_reg && !sync2_reg) begin
               state_next = R_START;
            end
         end
         R_START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next   = '0;
               bit_next   = 3'd0;
               state_next = sync2_reg ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               shift_next = {sync2_reg, shift_reg[7:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) begin
                  state_next = R_STOP;
               end
            end
         end
         R_STOP: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next       = '0;
               state_next     = R_IDLE;
               byte_valid     = sync2_reg;
               frame_err_next = !sync2_reg;
            end
         end
         default: state_next = R_IDLE;
      endcase
   end

   assign byte_data = shift_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: rtl/uart_link.sv
// UART-side engine of the register block: polls status, fetches and shifts
// out TX bytes, and writes received bytes back into the RX register.
module uart_link
   import uart_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        tx_busy,
   output logic        frame_err,
   output logic        overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   bus_state_t       state_reg, state_next;
   logic             rx_pending_reg, rx_pending_next;
   logic [7:0]       rx_byte_reg, rx_byte_next;
   logic             overrun_reg, overrun_next;
   logic             tx_busy_reg, tx_busy_next;
   logic [9:0]       tx_frame_reg, tx_frame_next;
   logic [CNT_W-1:0] tx_clk_cnt_reg, tx_clk_cnt_next;
   logic [3:0]       tx_bit_cnt_reg, tx_bit_cnt_next;

   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_last, tx_idle;
   logic       unused_rdata;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_core (
      .clk       (clk),
      .reset     (reset),
      .rx        (uart_rx),
      .byte_valid(rx_valid),
      .byte_data (rx_data),
      .frame_err (frame_err)
   );

   // Treating the final stop-bit cycle as idle lets POLL follow the frame
   // immediately; FETCH counts as busy because the start is already committed.
   assign tx_last = tx_busy_reg && (tx_clk_cnt_reg == BIT_LAST) && (tx_bit_cnt_reg == 4'd9);
   assign tx_idle = (!tx_busy_reg && (state_reg != B_FETCH)) || tx_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= B_IDLE;
         rx_pending_reg <= 1'b0;
         rx_byte_reg    <= 8'h00;
         overrun_reg    <= 1'b0;
         tx_busy_reg    <= 1'b0;
         tx_frame_reg   <= 10'h3FF;
         tx_clk_cnt_reg <= '0;
         tx_bit_cnt_reg <= 4'd0;
      end else begin
         state_reg      <= state_next;
         rx_pending_reg <= rx_pending_next;
         rx_byte_reg    <= rx_byte_next;
         overrun_reg    <= overrun_next;
         tx_busy_reg    <= tx_busy_next;
         tx_frame_reg   <= tx_frame_next;
         tx_clk_cnt_reg <= tx_clk_cnt_next;
         tx_bit_cnt_reg <= tx_bit_cnt_next;
      end
   end

   always_comb begin
      state_next      = B_IDLE;
      rx_pending_next = rx_pending_reg;
      rx_byte_next    = rx_byte_reg;
      overrun_next    = overrun_reg;

      if (rx_pending_reg) begin
         state_next      = B_WRITE;
         rx_pending_next = 1'b0;
      end else if ((state_reg == B_POLL) && mem_rdata[STAT_TX_DONE] && tx_idle) begin
         state_next = B_FETCH;
      end else if (tx_idle) begin
         state_next = B_POLL;
      end

      // A new byte always wins over the clear of the byte being written.
      if (rx_valid) begin
         rx_byte_next    = rx_data;
         rx_pending_next = 1'b1;
         if (rx_pending_reg) begin
            overrun_next = 1'b1;
         end
      end
   end

   always_comb begin
      tx_busy_next    = tx_busy_reg;
      tx_frame_next   = tx_frame_reg;
      tx_clk_cnt_next = tx_clk_cnt_reg;
      tx_bit_cnt_next = tx_bit_cnt_reg;
      if (state_reg == B_FETCH) begin
         tx_busy_next    = 1'b1;
         tx_frame_next   = {1'b1, mem_rdata[7:0], 1'b0};
         tx_clk_cnt_next = '0;
         tx_bit_cnt_next = 4'd0;
      end else if (tx_busy_reg) begin
         if (tx_clk_cnt_reg == BIT_LAST) begin
            tx_clk_cnt_next = '0;
            tx_frame_next   = {1'b1, tx_frame_reg[9:1]};
            tx_bit_cnt_next = tx_bit_cnt_reg + 4'd1;
            if (tx_bit_cnt_reg == 4'd9) begin
               tx_busy_next = 1'b0;
            end
         end else begin
            tx_clk_cnt_next = tx_clk_cnt_reg + 1'b1;
         end
      end
   end

   always_comb begin
      mem_addr  = 32'h0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = 32'h0;
      case (state_reg)
         B_POLL: begin
            mem_addr  = {24'h0, UART_STAT_ADDR};
            mem_rd_en = 1'b1;
         end
         B_FETCH: begin
            mem_addr  = {24'h0, UART_TX_ADDR};
            mem_rd_en = 1'b1;
         end
         B_WRITE: begin
            mem_addr  = {24'h0, UART_RX_ADDR};
            mem_wr_en = 1'b1;
            mem_wdata = {24'h0, rx_byte_reg};
         end
         default: ;
      endcase
   end

   assign unused_rdata = &{1'b0, mem_rdata[31:8]};
   assign uart_tx      = tx_busy_reg ? tx_frame_reg[0] : 1'b1;
   assign tx_busy      = tx_busy_reg;
   assign overrun      = overrun_reg;

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link with a small behavioural register block
// (TX/RX/status) attached to the memory port.
module tb_uart_link;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rd_en, mem_wr_en;
   logic        uart_rx, uart_tx, tx_busy, frame_err, overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_link #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .mem_addr (mem_addr),
      .mem_rd_en(mem_rd_en),
      .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .uart_rx  (uart_rx),
      .uart_tx  (uart_tx),
      .tx_busy  (tx_busy),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   // Register block model: TX write sets tx_done, a read of 0x18 clears it,
   // a write of 0x1C stores the byte and sets rx_done.
   logic [7:0] tx_reg, rx_reg, cpu_tx_data;
   logic       tx_done, rx_done, cpu_tx_wr, cpu_rx_ack;

   always_comb begin
      mem_rdata = 32'h0;
      case (mem_addr[7:0])
         8'h18: mem_rdata = {24'h0, tx_reg};
         8'h1C: mem_rdata = {24'h0, rx_reg};
         8'h20: begin
            mem_rdata[2] = tx_done;
            mem_rdata[3] = rx_done;
         end
         default: ;
      endcase
   end

   always @(posedge clk) begin
      if (reset) begin
         tx_reg  <= 8'h00;
         rx_reg  <= 8'h00;
         tx_done <= 1'b0;
         rx_done <= 1'b0;
      end else begin
         if (mem_rd_en && mem_addr[7:0] == 8'h18) tx_done <= 1'b0;
         if (cpu_tx_wr) begin
            tx_reg  <= cpu_tx_data;
            tx_done <= 1'b1;
         end
         if (mem_wr_en && mem_addr[7:0] == 8'h1C) begin
            rx_reg  <= mem_wdata[7:0];
            rx_done <= 1'b1;
         end
         if (cpu_rx_ack) rx_done <= 1'b0;
      end
   end

   int          cyc = 0, wr_cnt = 0, fetch_cnt = 0, fe_cnt = 0;
   int          last_wr_cyc = 0, last_fetch_cyc = 0;
   logic [31:0] last_wdata = 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_wr_en && mem_addr[7:0] == 8'h1C) begin
         wr_cnt      <= wr_cnt + 1;
         last_wdata  <= mem_wdata;
         last_wr_cyc <= cyc;
      end
      if (mem_rd_en && mem_addr[7:0] == 8'h18) begin
         fetch_cnt      <= fetch_cnt + 1;
         last_fetch_cyc <= cyc;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("chk  %s got=%h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_write_tx(input logic [7:0] d);
      cpu_tx_data = d;
      cpu_tx_wr   = 1'b1;
      tick(1);
      cpu_tx_wr   = 1'b0;
   endtask

   task automatic cpu_ack_rx();
      cpu_rx_ack = 1'b1;
      tick(1);
      cpu_rx_ack = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      uart_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         tick(CPB);
      end
      uart_rx = stop;
      tick(CPB);
      uart_rx = 1'b1;
   endtask

   task automatic wait_tx_fall(input int max, output int n);
      n = 0;
      while (uart_tx === 1'b1 && n < max) begin
         tick(1);
         n++;
      end
   endtask

   // Starts on the negedge where the start bit was first seen; samples mid-bit.
   task automatic tx_capture(output logic [9:0] bits);
      tick(CPB / 2);
      bits[0] = uart_tx;
      for (int i = 1; i < 10; i++) begin
         tick(CPB);
         bits[i] = uart_tx;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          w0, f0, fc0;
      logic [9:0]  bits, exp_bits;

      reset       = 1'b1;
      uart_rx     = 1'b1;
      cpu_tx_wr   = 1'b0;
      cpu_rx_ack  = 1'b0;
      cpu_tx_data = 8'h00;
      tick(4);
      check_eq("rst_uart_tx", uart_tx, 1);
      check_eq("rst_rd_en", mem_rd_en, 0);
      check_eq("rst_wr_en", mem_wr_en, 0);
      check_eq("rst_addr", mem_addr, 0);
      check_eq("rst_wdata", mem_wdata, 0);
      check_eq("rst_tx_busy", tx_busy, 0);
      check_eq("rst_frame_err", frame_err, 0);
      check_eq("rst_overrun", overrun, 0);
      reset = 1'b0;
      tick(3);

      // TX 0xA5: fetch within 3 cycles, then frame bits at mid-bit
      fc0 = fetch_cnt;
      cpu_write_tx(8'hA5);
      wait_tx_fall(10, n);
      check_eq("tx1_start_seen", uart_tx, 0);
      check_eq("tx1_lat_le3", (n <= 3), 1);
      check_eq("tx1_fetches", fetch_cnt - fc0, 1);
      check_eq("tx1_done_clr", tx_done, 0);
      check_eq("tx1_busy", tx_busy, 1);
      tx_capture(bits);
      exp_bits = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("tx1_bit%0d", i), bits[i], exp_bits[i]);
      end
      tick(CPB / 2 + 1);
      check_eq("tx1_busy_end", tx_busy, 0);

      // RX 0x3C, good stop bit
      w0 = wr_cnt;
      send_frame(8'h3C, 1'b1);
      tick(20);
      check_eq("rx1_writes", wr_cnt - w0, 1);
      check_eq("rx1_wdata", last_wdata, 32'h3C);
      check_eq("rx1_rx_done", rx_done, 1);
      check_eq("rx1_rx_reg", rx_reg, 8'h3C);
      check_eq("rx1_overrun", overrun, 0);
      cpu_ack_rx();

      // RX 0x81 with a low stop bit
      w0 = wr_cnt;
      f0 = fe_cnt;
      send_frame(8'h81, 1'b0);
      tick(30);
      check_eq("fe_pulses", fe_cnt - f0, 1);
      check_eq("fe_writes", wr_cnt - w0, 0);
      check_eq("fe_rx_done", rx_done, 0);

      // 8-cycle low glitch
      w0 = wr_cnt;
      f0 = fe_cnt;
      uart_rx = 1'b0;
      tick(8);
      uart_rx = 1'b1;
      tick(40);
      check_eq("gl_writes", wr_cnt - w0, 0);
      check_eq("gl_fe", fe_cnt - f0, 0);
      check_eq("gl_rx_done", rx_done, 0);

      // RX 0xF0 completes on the same edge as the CPU writes TX 0x55
      w0  = wr_cnt;
      fc0 = fetch_cnt;
      fork
         send_frame(8'hF0, 1'b1);
         begin
            tick(154);
            cpu_write_tx(8'h55);
            wait_tx_fall(10, n);
            check_eq("dx_start_seen", uart_tx, 0);
            check_eq("dx_lat_le4", (n <= 4), 1);
            tx_capture(bits);
            check_eq("dx_tx_frame", bits, {1'b1, 8'h55, 1'b0});
         end
      join
      tick(5);
      check_eq("dx_writes", wr_cnt - w0, 1);
      check_eq("dx_wdata", last_wdata, 32'hF0);
      check_eq("dx_fetches", fetch_cnt - fc0, 1);
      check_eq("dx_wr_first", (last_wr_cyc < last_fetch_cyc), 1);
      check_eq("dx_overrun", overrun, 0);
      cpu_ack_rx();

      // Reset in the middle of data bit 4 of 0x0F
      cpu_write_tx(8'h0F);
      wait_tx_fall(10, n);
      check_eq("rs_start_seen", uart_tx, 0);
      tick(CPB / 2 + CPB * 5);
      check_eq("rs_bit4_low", uart_tx, 0);
      reset = 1'b1;
      tick(1);
      check_eq("rs_uart_tx", uart_tx, 1);
      check_eq("rs_tx_busy", tx_busy, 0);
      check_eq("rs_rd_en", mem_rd_en, 0);
      check_eq("rs_wr_en", mem_wr_en, 0);
      check_eq("rs_addr", mem_addr, 0);
      check_eq("rs_wdata", mem_wdata, 0);
      check_eq("rs_overrun", overrun, 0);
      reset = 1'b0;
      tick(3);
      cpu_write_tx(8'h96);
      wait_tx_fall(10, n);
      check_eq("rs_tx2_start", uart_tx, 0);
      tx_capture(bits);
      check_eq("rs_tx2_frame", bits, {1'b1, 8'h96, 1'b0});

      tick(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
